// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with press and release debounce.
// Build option KEYPAD_SYNC_EN: rows pass through a two-flop synchroniser before use.
module keypad_scanner #(
   parameter int unsigned SETTLE_CYCLES   = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 480000,
   parameter int unsigned CNT_W           = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state, state_nx;
   logic [1:0]       col, col_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       pat, pat_nx;
   logic [3:0]       code_nx;
   logic             valid_nx;
   logic             one_low;

`ifdef KEYPAD_SYNC_EN
   logic [3:0] rows_m, rows_s;
   always_ff @(posedge clk) begin
      if (!reset) begin
         rows_m <= '1;
         rows_s <= '1;
      end else begin
         rows_m <= rows;
         rows_s <= rows_m;
      end
   end
`else
   logic [3:0] rows_s;
   assign rows_s = rows;
`endif

   function automatic logic [3:0] key_map(input logic [3:0] p, input logic [1:0] c);
      logic [1:0] r;
      logic [3:0] k;
      case (p)
         4'b1110: r = 2'd0;
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         default: r = 2'd3;
      endcase
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
         4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   always_comb begin
      case (rows_s)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
         default:                            one_low = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      col_nx   = col;
      cnt_nx   = cnt;
      pat_nx   = pat;
      code_nx  = key_code;
      valid_nx = 1'b0;
      if (!en) begin
         state_nx = SCAN;
         col_nx   = '0;
         cnt_nx   = '0;
      end else begin
         case (state)
            SCAN: begin
               if (cnt == SETTLE_LAST) begin
                  cnt_nx = '0;
                  if (one_low) begin
                     pat_nx   = rows_s;
                     state_nx = DEBOUNCE;
                  end else begin
                     col_nx = col + 2'd1;
                  end
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end
            DEBOUNCE: begin
               if (rows_s != pat) begin
                  cnt_nx   = '0;
                  col_nx   = col + 2'd1;
                  state_nx = SCAN;
               end else if (cnt == DEB_LAST) begin
                  cnt_nx   = '0;
                  code_nx  = key_map(pat, col);
                  valid_nx = 1'b1;
                  state_nx = HELD;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end
            HELD: begin
               // Any low row, including a second key, restarts the release count.
               if (rows_s != 4'b1111) begin
                  cnt_nx = '0;
               end else if (cnt == DEB_LAST) begin
                  cnt_nx   = '0;
                  col_nx   = '0;
                  state_nx = SCAN;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end
            default: begin
               state_nx = SCAN;
               col_nx   = '0;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= SCAN;
         col       <= '0;
         cnt       <= '0;
         pat       <= '1;
         key_code  <= '0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         col       <= col_nx;
         cnt       <= cnt_nx;
         pat       <= pat_nx;
         key_code  <= code_nx;
         key_valid <= valid_nx;
      end
   end

   assign cols     = en ? ~(4'b0001 << col) : 4'b1111;
   assign key_held = en && (state == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from cols and pressed keys.
module tb_keypad_scanner;

   localparam int S = 4;
   localparam int D = 8;

   logic       clk;
   logic       reset;
   logic       en;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys;
   logic [3:0]  exp_q[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;

   keypad_scanner #(
      .SETTLE_CYCLES  (S),
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .rows     (rows),
      .cols     (cols),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A pressed key at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      rows = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int r, input int c);
      keys[r*4+c] = 1'b1;
   endtask

   task automatic release_key(input int r, input int c);
      keys[r*4+c] = 1'b0;
   endtask

   task automatic restart();
      en = 1'b0;
      tick(1);
      en = 1'b1;
   endtask

   task automatic wait_valid(input string name, input int exp_lat);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (key_valid !== 1'b1 && n < 200);
      check(name, n, exp_lat);
   endtask

   // Monitor: every key_valid strobe must match the next queued key code.
   initial begin
      forever begin
         @(negedge clk);
         if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_valid", key_valid, 0);
            else check("sb_key_code", key_code, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0] ec;
      reset = 1'b0;
      en    = 1'b1;
      keys  = '0;

      // Reset and idle scan sequence
      tick(1);
      @(negedge clk);
      check("rst_cols", cols, 4'b1110);
      check("rst_code", key_code, 4'h0);
      check("rst_held", key_held, 0);
      check("rst_valid", key_valid, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int j = 0; j <= 16; j++) begin
         @(negedge clk);
         ec = ~(4'b0001 << ((j / 4) % 4));
         check($sformatf("scan_cols_%0d", j), cols, ec);
         tick(1);
      end

      // Key 5 (row1,col1): latency S*2+D, then exact release timing
      press(1, 1);
      exp_q.push_back(4'h5);
      restart();
      wait_valid("lat_key5", S*2 + D);
      check("held_key5", key_held, 1);
      tick(1);
      release_key(1, 1);
      tick(D - 1);
      @(negedge clk);
      check("rel5_still_held", key_held, 1);
      tick(1);
      @(negedge clk);
      check("rel5_released", key_held, 0);

      // Bounce during DEBOUNCE: scan resumes at col2, key accepted next pass
      press(1, 1);
      exp_q.push_back(4'h5);
      restart();
      tick(S*2);
      tick(5);
      release_key(1, 1);
      tick(1);
      @(negedge clk);
      check("bounce_cols", cols, 4'b1011);
      check("bounce_held", key_held, 0);
      press(1, 1);
      wait_valid("lat_bounce", S*4 + D);
      keys = '0;
      tick(D + 4);
      @(negedge clk);
      check("bounce_rel", key_held, 0);

      // Two rows low on col0: no capture, scan advances
      press(1, 0);
      press(2, 0);
      restart();
      tick(S);
      @(negedge clk);
      check("multi_cols", cols, 4'b1101);
      tick(40);
      @(negedge clk);
      check("multi_held", key_held, 0);
      keys = '0;
      tick(2);

      // Key 0 (row3,col1): short release is ignored, single strobe
      press(3, 1);
      exp_q.push_back(4'h0);
      restart();
      wait_valid("lat_key0", S*2 + D);
      check("code_key0", key_code, 4'h0);
      tick(1);
      release_key(3, 1);
      tick(5);
      press(3, 1);
      tick(1);
      @(negedge clk);
      check("short_rel_held", key_held, 1);
      tick(10);
      @(negedge clk);
      check("repress_held", key_held, 1);
      @(posedge clk); #1;
      release_key(3, 1);
      tick(D - 1);
      @(negedge clk);
      check("rel0_still_held", key_held, 1);
      tick(1);
      @(negedge clk);
      check("rel0_released", key_held, 0);
      check("code_key0_kept", key_code, 4'h0);

      // en drop while HELD on key 8 (row2,col1)
      press(2, 1);
      exp_q.push_back(4'h8);
      restart();
      wait_valid("lat_key8", S*2 + D);
      check("held_key8", key_held, 1);
      tick(1);
      en = 1'b0;
      tick(1);
      @(negedge clk);
      check("endrop_cols", cols, 4'b1111);
      check("endrop_held", key_held, 0);
      check("endrop_code", key_code, 4'h8);
      release_key(2, 1);
      @(posedge clk); #1;
      en = 1'b1;

      // Reset mid-DEBOUNCE
      press(2, 1);
      restart();
      tick(S*2 + 3);
      reset = 1'b0;
      tick(1);
      @(negedge clk);
      check("rstdeb_cols", cols, 4'b1110);
      check("rstdeb_held", key_held, 0);
      check("rstdeb_valid", key_valid, 0);
      check("rstdeb_code", key_code, 4'h0);
      keys = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      tick(40);
      @(negedge clk);
      check("final_held", key_held, 0);
      check("sb_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
